// File: rtl/ss2_reset_gen.sv
// Reset pulse generator for ss2/DUT logic: one pulse after power-up, then one
// per software request or per qualified UART break (rxd held low).
module ss2_reset_gen #(
  parameter int unsigned pSTARTUP_WIDTH = 10,
  parameter int unsigned pPULSE_CYCLES  = 4,
  parameter int unsigned pBREAK_CYCLES  = 3200,
  parameter int unsigned pSYNC_STAGES   = 2,
  parameter int unsigned pBREAK_ENABLE  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  input  logic       sw_reset_req,
  output logic       ss2_reset,
  output logic       ss2_resetn,
  output logic [1:0] reset_cause,
  output logic [7:0] reset_count,
  output logic       break_active
);

  localparam int unsigned BRK_W = $clog2(pBREAK_CYCLES + 1);

  localparam logic [1:0] CAUSE_STARTUP = 2'b01;
  localparam logic [1:0] CAUSE_BREAK   = 2'b10;
  localparam logic [1:0] CAUSE_SW      = 2'b11;

  typedef enum logic [1:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_PULSE,
    ST_WAIT_RXD_HIGH
  } state_t;

  state_t                    state_q = ST_STARTUP;
  state_t                    state_d;
  logic [pSTARTUP_WIDTH-1:0] start_cnt_q = '0;
  logic [pSTARTUP_WIDTH-1:0] start_cnt_d;
  logic [7:0]                pulse_cnt_q = '0;
  logic [7:0]                pulse_cnt_d;
  logic [pSYNC_STAGES-1:0]   sync_q = '1;
  logic [BRK_W-1:0]          brk_cnt_q = '0;
  logic [BRK_W-1:0]          brk_cnt_d;
  logic                      ss2_reset_q = 1'b0;
  logic                      ss2_resetn_q = 1'b1;
  logic [1:0]                cause_q = 2'b00;
  logic [1:0]                cause_d;
  logic [7:0]                count_q = 8'd0;
  logic [7:0]                count_d;
  logic                      ss2_reset_d;
  logic                      rxd_s;
  logic                      brk_trig;
  logic                      fire;
  logic [1:0]                fire_cause;

  assign rxd_s = sync_q[pSYNC_STAGES-1];

  // Trigger on the edge where the low-run counter steps onto the threshold.
  always_comb begin
    brk_cnt_d = brk_cnt_q;
    brk_trig  = 1'b0;
    if (rxd_s) begin
      brk_cnt_d = '0;
    end else if (brk_cnt_q != BRK_W'(pBREAK_CYCLES)) begin
      brk_cnt_d = brk_cnt_q + 1'b1;
      brk_trig  = (pBREAK_ENABLE != 0) && (brk_cnt_q == BRK_W'(pBREAK_CYCLES - 1));
    end
  end

  always_comb begin
    state_d     = state_q;
    start_cnt_d = start_cnt_q;
    pulse_cnt_d = pulse_cnt_q;
    cause_d     = cause_q;
    count_d     = count_q;
    fire        = 1'b0;
    fire_cause  = 2'b00;
    case (state_q)
      ST_STARTUP: begin
        if (start_cnt_q == '1) begin
          fire       = 1'b1;
          fire_cause = CAUSE_STARTUP;
        end else begin
          start_cnt_d = start_cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        // Break wins over a coincident software request.
        if (brk_trig) begin
          fire       = 1'b1;
          fire_cause = CAUSE_BREAK;
        end else if (sw_reset_req) begin
          fire       = 1'b1;
          fire_cause = CAUSE_SW;
        end
      end
      ST_PULSE: begin
        if (pulse_cnt_q == 8'(pPULSE_CYCLES - 1)) begin
          state_d = (cause_q == CAUSE_BREAK) ? ST_WAIT_RXD_HIGH : ST_IDLE;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 1'b1;
        end
      end
      ST_WAIT_RXD_HIGH: begin
        if (rxd_s) state_d = ST_IDLE;
      end
      default: state_d = ST_STARTUP;
    endcase
    if (fire) begin
      state_d     = ST_PULSE;
      pulse_cnt_d = 8'd0;
      cause_d     = fire_cause;
      count_d     = (count_q == 8'hFF) ? count_q : count_q + 1'b1;
    end
    ss2_reset_d = (state_d == ST_PULSE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_STARTUP;
      start_cnt_q  <= '0;
      pulse_cnt_q  <= 8'd0;
      sync_q       <= '1;
      brk_cnt_q    <= '0;
      ss2_reset_q  <= 1'b0;
      ss2_resetn_q <= 1'b1;
      cause_q      <= 2'b00;
      count_q      <= 8'd0;
    end else begin
      state_q      <= state_d;
      start_cnt_q  <= start_cnt_d;
      pulse_cnt_q  <= pulse_cnt_d;
      sync_q       <= {sync_q[pSYNC_STAGES-2:0], rxd};
      brk_cnt_q    <= brk_cnt_d;
      ss2_reset_q  <= ss2_reset_d;
      ss2_resetn_q <= ~ss2_reset_d;
      cause_q      <= cause_d;
      count_q      <= count_d;
    end
  end

  assign ss2_reset    = ss2_reset_q;
  assign ss2_resetn   = ss2_resetn_q;
  assign reset_cause  = cause_q;
  assign reset_count  = count_q;
  assign break_active = (brk_cnt_q == BRK_W'(pBREAK_CYCLES));

endmodule

// File: tb/tb_ss2_reset_gen.sv
// Bench for ss2_reset_gen: directed scenarios plus randomized rxd/request
// traffic, every cycle compared against an event-level reference model.
module tb_ss2_reset_gen;

  localparam int W = 4;
  localparam int P = 3;
  localparam int B = 8;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       sw_reset_req = 1'b0;
  logic       ss2_reset;
  logic       ss2_resetn;
  logic [1:0] reset_cause;
  logic [7:0] reset_count;
  logic       break_active;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_sync [S];
  int m_elapsed;
  bit m_started;
  int m_left;
  int m_cause;
  int m_count;
  int m_low;
  bit m_wait;

  ss2_reset_gen #(
    .pSTARTUP_WIDTH(W),
    .pPULSE_CYCLES (P),
    .pBREAK_CYCLES (B),
    .pSYNC_STAGES  (S),
    .pBREAK_ENABLE (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rxd         (rxd),
    .sw_reset_req(sw_reset_req),
    .ss2_reset   (ss2_reset),
    .ss2_resetn  (ss2_resetn),
    .reset_cause (reset_cause),
    .reset_count (reset_count),
    .break_active(break_active)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fire(input int c);
    m_left    = P;
    m_cause   = c;
    m_count   = (m_count < 255) ? m_count + 1 : 255;
    m_started = 1'b1;
  endtask

  task automatic model_edge(input bit r, input bit rx, input bit sw);
    bit rs;
    bit trig;
    if (r) begin
      for (int i = 0; i < S; i++) m_sync[i] = 1'b1;
      m_elapsed = 0; m_started = 1'b0; m_left = 0; m_cause = 0;
      m_count = 0; m_low = 0; m_wait = 1'b0;
      return;
    end
    rs = m_sync[S-1];
    for (int i = S - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
    m_sync[0] = rx;
    trig  = !rs && (m_low == B - 1);
    m_low = rs ? 0 : ((m_low < B) ? m_low + 1 : B);
    if (!m_started) begin
      if (m_elapsed == (1 << W) - 1) fire(1);
      else m_elapsed++;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_cause == 2) m_wait = 1'b1;
    end else if (m_wait) begin
      if (rs) m_wait = 1'b0;
    end else if (trig) begin
      fire(2);
    end else if (sw) begin
      fire(3);
    end
  endtask

  task automatic step(input bit r, input bit rx, input bit sw);
    reset = r; rxd = rx; sw_reset_req = sw;
    @(posedge clk);
    model_edge(r, rx, sw);
    #1;
    check_eq("ss2_reset",    int'(ss2_reset),    (m_left > 0) ? 1 : 0);
    check_eq("ss2_resetn",   int'(ss2_resetn),   (m_left > 0) ? 0 : 1);
    check_eq("reset_cause",  int'(reset_cause),  m_cause);
    check_eq("reset_count",  int'(reset_count),  m_count);
    check_eq("break_active", int'(break_active), (m_low == B) ? 1 : 0);
  endtask

  initial begin
    int run;
    bit lvl;
    bit sw;
    bit rst;
    bit seen_pulse;

    for (int i = 0; i < S; i++) m_sync[i] = 1'b1;
    m_elapsed = 0; m_started = 1'b0; m_left = 0; m_cause = 0;
    m_count = 0; m_low = 0; m_wait = 1'b0;

    // Reset state
    step(1, 1, 0);
    step(1, 1, 0);
    check_eq("rst_ss2_reset", int'(ss2_reset), 0);
    check_eq("rst_resetn", int'(ss2_resetn), 1);
    check_eq("rst_count", int'(reset_count), 0);

    // Startup: low for 15 clocks, high on 16..18
    for (int k = 1; k <= 20; k++) begin
      step(0, 1, 0);
      check_eq("startup_shape", int'(ss2_reset), (k >= 16 && k <= 18) ? 1 : 0);
    end
    check_eq("startup_cause", int'(reset_cause), 1);
    check_eq("startup_count", int'(reset_count), 1);

    // Software request, plus a second request during the pulse
    step(0, 1, 1);
    step(0, 1, 0);
    step(0, 1, 1);
    step(0, 1, 0);
    step(0, 1, 0);
    check_eq("sw_cause", int'(reset_cause), 3);
    check_eq("sw_count", int'(reset_count), 2);
    check_eq("sw_ended", int'(ss2_reset), 0);

    // Short low run: no pulse
    repeat (7) step(0, 0, 0);
    repeat (6) step(0, 1, 0);
    check_eq("short_low_count", int'(reset_count), 2);

    // Held break: exactly one pulse
    seen_pulse = 1'b0;
    for (int k = 0; k < 100; k++) begin
      step(0, 0, 0);
      if (k == 50) begin
        check_eq("brk_active_held", int'(break_active), 1);
        check_eq("brk_cause", int'(reset_cause), 2);
      end
    end
    check_eq("brk_count", int'(reset_count), 3);
    repeat (6) step(0, 1, 0);
    check_eq("brk_active_clr", int'(break_active), 0);
    check_eq("brk_count_after", int'(reset_count), 3);

    // Break trigger coincident with software request
    for (int k = 0; k < 30; k++) begin
      sw = (m_sync[S-1] == 1'b0) && (m_low == B - 1);
      step(0, 0, sw);
    end
    repeat (6) step(0, 1, 0);
    check_eq("both_cause", int'(reset_cause), 2);
    check_eq("both_count", int'(reset_count), 4);

    // Randomized traffic
    for (int k = 0; k < 150; k++) begin
      run = $urandom_range(1, 20);
      lvl = ($urandom_range(0, 2) != 0);
      for (int j = 0; j < run; j++) begin
        sw  = ($urandom_range(0, 7) == 0);
        rst = ($urandom_range(0, 399) == 0);
        step(rst, lvl, sw);
      end
    end

    // Reset during the second pulse cycle
    step(1, 1, 0);
    repeat (20) step(0, 1, 0);
    step(0, 1, 1);
    step(0, 1, 0);
    step(1, 1, 0);
    check_eq("abort_ss2_reset", int'(ss2_reset), 0);
    check_eq("abort_count", int'(reset_count), 0);
    repeat (20) step(0, 1, 0);
    check_eq("restart_count", int'(reset_count), 1);
    check_eq("restart_cause", int'(reset_cause), 1);

    // Count saturation
    for (int k = 0; k < 300; k++) begin
      step(0, 1, 1);
      repeat (4) step(0, 1, 0);
    end
    check_eq("sat_count", int'(reset_count), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ss2_reset_gen.md
SS2_RESET_GEN -- requirements
Module: ss2_reset_gen

Interface
REQ-001 Parameter pSTARTUP_WIDTH, default 10: width of the power-up delay counter.
REQ-002 Parameter pPULSE_CYCLES, default 4, range 1..255: length of each generated reset pulse in clk cycles.
REQ-003 Parameter pBREAK_CYCLES, default 3200, minimum 2: consecutive synchronised-low rxd cycles that constitute a break.
REQ-004 Parameter pSYNC_STAGES, default 2, minimum 2: rxd synchroniser depth.
REQ-005 Parameter pBREAK_ENABLE, default 1: 0 disables break-triggered resets.
REQ-006 clk  input  1  sole clock; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset; may be tied 0.
REQ-008 rxd  input  1  asynchronous UART receive line, idle high.
REQ-009 sw_reset_req  input  1  single-cycle software reset request.
REQ-010 ss2_reset  output  1  registered active-high reset to downstream ss2/DUT logic.
REQ-011 ss2_resetn  output  1  registered complement of ss2_reset.
REQ-012 reset_cause  output  2  cause of last pulse: 00 none, 01 startup, 10 break, 11 software.
REQ-013 reset_count  output  8  number of pulses issued since reset, saturating at 255.
REQ-014 break_active  output  1  high while a qualified break is in progress.

Function
REQ-015 FSM states SHALL be STARTUP, IDLE, PULSE, WAIT_RXD_HIGH.
REQ-016 STARTUP: startup counter increments from 0 each cycle; when counter equals all-ones, the next state SHALL be PULSE with cause 01.
REQ-017 ss2_reset SHALL be low in STARTUP, so the first pulse rises on the 2^pSTARTUP_WIDTH-th clock after reset deassertion.
REQ-018 PULSE: ss2_reset SHALL be high for exactly pPULSE_CYCLES consecutive cycles, then go to WAIT_RXD_HIGH if cause is 10, else to IDLE.
REQ-019 On entry to PULSE, reset_cause SHALL update and reset_count SHALL increment, holding at 255.
REQ-020 rxd SHALL pass through pSYNC_STAGES flops reset to 1; only the last stage is used.
REQ-021 The break counter SHALL count consecutive synchronised-low cycles, saturate at pBREAK_CYCLES, and clear on any synchronised-high cycle.
REQ-022 Break trigger SHALL fire on the cycle the break counter reaches pBREAK_CYCLES, if pBREAK_ENABLE=1.
REQ-023 break_active SHALL be high while the break counter equals pBREAK_CYCLES.
REQ-024 IDLE: break trigger or sw_reset_req sampled high at cycle N SHALL raise ss2_reset at cycle N+1.
REQ-025 A simultaneous break trigger and sw_reset_req SHALL produce one pulse with cause 10.
REQ-026 sw_reset_req and break triggers SHALL be ignored in STARTUP, PULSE and WAIT_RXD_HIGH.
REQ-027 WAIT_RXD_HIGH SHALL return to IDLE only after the synchronised rxd is high, so one held break yields exactly one pulse.
REQ-028 ss2_resetn SHALL equal ~ss2_reset on every cycle.

Reset
REQ-029 reset high SHALL, on the next edge, force STARTUP, clear all counters, set synchroniser flops to 1, and drive ss2_reset=0, ss2_resetn=1, reset_cause=00, reset_count=0, break_active=0.
REQ-030 reset asserted mid-PULSE or mid-break SHALL abort it on the next edge and restart STARTUP.
REQ-031 All registers SHALL carry power-up initial values equal to their reset values, so operation is correct with reset tied 0.

Verification (pSTARTUP_WIDTH=4, pPULSE_CYCLES=3, pBREAK_CYCLES=8, pSYNC_STAGES=2)
REQ-032 Release reset -> ss2_reset low for 15 clocks, high on clocks 16-18, reset_cause=01, reset_count=1.
REQ-033 One-cycle sw_reset_req in IDLE at cycle N -> ss2_reset high on N+1..N+3, cause=11, count increments; a request at N+2 produces no extra pulse.
REQ-034 rxd low for 7 synchronised cycles then high -> no pulse; rxd low for 100 cycles -> exactly one 3-cycle pulse, cause=10, break_active high until rxd returns high, and no further pulse.
REQ-035 Break trigger and sw_reset_req in the same cycle -> single pulse, cause=10.
REQ-036 reset asserted during the second PULSE cycle -> ss2_reset=0 on the next edge, count=0, and the startup sequence restarts.
REQ-037 300 software requests spaced 5 cycles apart -> reset_count saturates at 255.
